// File: rtl/dct_pkg.sv
// Shared constants, FSM encoding and the DCT cosine coefficient function
// used by the row feeder and its coefficient ROM.
package dct_pkg;

  localparam int PIX_W       = 8;
  localparam int PROD_W      = 12;
  localparam int K_W         = 3;
  localparam int N_PIX       = 8;
  localparam int COEF_W      = 7;
  localparam int X_W         = PIX_W + 1;
  localparam int LEVEL_SHIFT = 128;

  // Rounded 32*cos(m*pi/16) for m = 0..8.
  localparam logic [5:0] COS_T [0:8] = '{
    6'd32, 6'd31, 6'd30, 6'd27, 6'd23, 6'd18, 6'd12, 6'd6, 6'd0
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic signed [COEF_W-1:0] coef_of(
    input logic [K_W-1:0] k,
    input logic [2:0]     i
  );
    logic [4:0]               m;
    logic [3:0]               r;
    logic [5:0]               mag;
    logic signed [COEF_W-1:0] c;
    m = {1'b0, i, 1'b1} * {2'b0, k};
    r = m[3:0];
    // Fold the upper half of each 16-step period back onto T[0..8].
    if (r <= 4'd8) mag = COS_T[r];
    else           mag = COS_T[4'd0 - r];
    c = $signed({1'b0, mag});
    if (k == '0)                       c = 7'sd23;
    else if (m > 5'd8 && m < 5'd24)    c = -c;
    return c;
  endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Combinational coefficient ROM: one signed cosine coefficient per pixel
// for the selected output index k.
module dct_coef_rom
  import dct_pkg::*;
(
  input  logic [K_W-1:0]           k,
  output logic signed [COEF_W-1:0] coef [N_PIX]
);

  for (genvar g = 0; g < N_PIX; g++) begin : g_coef
    assign coef[g] = coef_of(k, 3'(g));
  end

endmodule

// File: rtl/dct_row_feeder.sv
// Accepts a row of eight pixels, then streams the eight scaled cosine
// product vectors (k = 0..7) to the adder tree with a delayed valid/k tag.
module dct_row_feeder
  import dct_pkg::*;
#(
  parameter int ADDER_LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_PIX*PIX_W-1:0]   pix_in,
  output logic signed [PROD_W-1:0] n0,
  output logic signed [PROD_W-1:0] n1,
  output logic signed [PROD_W-1:0] n2,
  output logic signed [PROD_W-1:0] n3,
  output logic signed [PROD_W-1:0] n4,
  output logic signed [PROD_W-1:0] n5,
  output logic signed [PROD_W-1:0] n6,
  output logic signed [PROD_W-1:0] n7,
  output logic                     prod_valid,
  output logic [K_W-1:0]           prod_k,
  output logic                     sum_valid,
  output logic [K_W-1:0]           sum_k,
  output logic                     sum_last,
  output state_t                   fsm_state
);

  // Handshake: a row transfers on a rising edge where in_valid & in_ready.
  // in_ready never depends on in_valid; upstream holds pix_in while waiting.

  localparam int               MUL_W  = X_W + COEF_W;
  localparam logic [K_W-1:0]   LAST_K = '1;

  state_t                   state, state_next;
  logic [K_W-1:0]           k;
  logic                     load, run;
  logic signed [X_W-1:0]    x     [N_PIX];
  logic signed [COEF_W-1:0] coef  [N_PIX];
  logic signed [MUL_W-1:0]  prod  [N_PIX];
  logic signed [PROD_W-1:0] n_r   [N_PIX];
  logic                     dl_valid [ADDER_LATENCY];
  logic [K_W-1:0]           dl_k     [ADDER_LATENCY];

  dct_coef_rom u_rom (
    .k    (k),
    .coef (coef)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_RUN;
      ST_RUN:  if (k == LAST_K && !in_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    run      = (state == ST_RUN);
    in_ready = !rst && (state == ST_IDLE || k == LAST_K);
    load     = in_valid && in_ready;
  end

  always_comb begin
    for (int i = 0; i < N_PIX; i++) begin
      prod[i] = MUL_W'(x[i]) * MUL_W'(coef[i]);
    end
  end

  // The >>> floors; the shifted product always fits PROD_W signed bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      prod_valid <= 1'b0;
      prod_k     <= '0;
      for (int i = 0; i < N_PIX; i++) begin
        x[i]   <= '0;
        n_r[i] <= '0;
      end
    end else begin
      prod_valid <= run;
      if (run) begin
        prod_k <= k;
        for (int i = 0; i < N_PIX; i++) begin
          n_r[i] <= PROD_W'(prod[i] >>> 1);
        end
      end
      if (load) begin
        k <= '0;
        for (int i = 0; i < N_PIX; i++) begin
          x[i] <= $signed({1'b0, pix_in[PIX_W*i +: PIX_W]}) - $signed(X_W'(LEVEL_SHIFT));
        end
      end else if (run) begin
        k <= k + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < ADDER_LATENCY; j++) begin
        dl_valid[j] <= 1'b0;
        dl_k[j]     <= '0;
      end
    end else begin
      dl_valid[0] <= prod_valid;
      dl_k[0]     <= prod_k;
      for (int j = 1; j < ADDER_LATENCY; j++) begin
        dl_valid[j] <= dl_valid[j-1];
        dl_k[j]     <= dl_k[j-1];
      end
    end
  end

  assign sum_valid = dl_valid[ADDER_LATENCY-1];
  assign sum_k     = dl_k[ADDER_LATENCY-1];
  assign sum_last  = sum_valid && (sum_k == LAST_K);
  assign fsm_state = state;

  assign n0 = n_r[0];
  assign n1 = n_r[1];
  assign n2 = n_r[2];
  assign n3 = n_r[3];
  assign n4 = n_r[4];
  assign n5 = n_r[5];
  assign n6 = n_r[6];
  assign n7 = n_r[7];

endmodule

// File: tb/tb_dct_row_feeder.sv
// Bench for dct_row_feeder: table vectors, corner sequences and random rows
// checked against a cosine-based reference model and a timed scoreboard.
module tb_dct_row_feeder;
  import dct_pkg::*;

  localparam int LAT = 5;
  localparam int EW  = 32 + 3 + 96;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [63:0]        pix_in = '0;
  logic signed [11:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic               prod_valid, sum_valid, sum_last;
  logic [2:0]         prod_k, sum_k;
  state_t             fsm_state;

  dct_row_feeder #(.ADDER_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pix_in(pix_in),
    .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6), .n7(n7),
    .prod_valid(prod_valid), .prod_k(prod_k),
    .sum_valid(sum_valid), .sum_k(sum_k), .sum_last(sum_last),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [34:0]   sum_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cap [8][8];
  int            run_len = 0, last_run = 0, sum_run = 0, last_sum_run = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_coef(input int k, input int i);
    real a;
    if (k == 0) return 23;
    a = 32.0 * $cos(3.141592653589793 * real'((2*i+1)*k) / 16.0);
    return int'($floor(a + 0.5));
  endfunction

  function automatic int model_n(input int pix, input int k, input int i);
    int p;
    p = (pix - 128) * model_coef(k, i);
    return int'($floor(real'(p) / 2.0));
  endfunction

  task automatic push_row(input logic [63:0] p, input int base);
    logic [95:0] nv;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) nv[12*i +: 12] = 12'(model_n(int'(p[8*i +: 8]), k, i));
      exp_q.push_back({32'(base + k), 3'(k), nv});
    end
  endtask

  // monitor
  logic [EW-1:0] me;
  logic [34:0]   ms;
  logic [11:0]   nv_act [8];
  always @(negedge clk) begin
    nv_act[0] = n0; nv_act[1] = n1; nv_act[2] = n2; nv_act[3] = n3;
    nv_act[4] = n4; nv_act[5] = n5; nv_act[6] = n6; nv_act[7] = n7;
    if (prod_valid) begin
      run_len++;
      if (exp_q.size() == 0) begin
        check("prod_spurious", 1, 0);
      end else begin
        me = exp_q.pop_front();
        check("prod_cycle", cyc, int'(me[130:99]));
        check("prod_k", int'(prod_k), int'(me[98:96]));
        for (int i = 0; i < 8; i++) begin
          check("prod_n", int'($signed(nv_act[i])), int'($signed(me[12*i +: 12])));
          cap[prod_k][i] = int'($signed(nv_act[i]));
        end
      end
      sum_q.push_back({32'(cyc + LAT), prod_k});
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (sum_valid) begin
      sum_run++;
      if (sum_q.size() == 0) begin
        check("sum_spurious", 1, 0);
      end else begin
        ms = sum_q.pop_front();
        check("sum_cycle", cyc, int'(ms[34:3]));
        check("sum_k", int'(sum_k), int'(ms[2:0]));
        check("sum_last", int'(sum_last), int'(ms[2:0] == 3'd7));
      end
    end else begin
      if (sum_run > 0) last_sum_run = sum_run;
      sum_run = 0;
      check("sum_last_idle", int'(sum_last), 0);
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_row(input logic [63:0] p, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    pix_in   = p;
    while (!in_ready && waits < 200) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      push_row(p, cyc + 2);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || sum_q.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    check("drain_timeout", exp_q.size() + sum_q.size(), 0);
    tick(2);
  endtask

  typedef struct {
    logic [63:0] pix;
    int          k;
    int          i;
    int          exp_n;
  } vec_t;

  vec_t        tbl [18];
  logic [63:0] p128, p255, pimp, pimn, p000;
  int          w;

  initial begin
    p128 = {8{8'h80}};
    p255 = {8{8'hFF}};
    pimp = {{7{8'h80}}, 8'h81};
    pimn = {{7{8'h80}}, 8'h7F};
    p000 = '0;
    tbl[0]  = '{p128, 0, 0, 0};
    tbl[1]  = '{p128, 5, 6, 0};
    tbl[2]  = '{p255, 0, 0, 1460};
    tbl[3]  = '{p255, 0, 7, 1460};
    tbl[4]  = '{p255, 4, 1, -1461};
    tbl[5]  = '{p255, 4, 3, 1460};
    tbl[6]  = '{pimp, 0, 0, 11};
    tbl[7]  = '{pimp, 1, 0, 15};
    tbl[8]  = '{pimp, 2, 0, 15};
    tbl[9]  = '{pimp, 3, 0, 13};
    tbl[10] = '{pimp, 4, 0, 11};
    tbl[11] = '{pimp, 5, 0, 9};
    tbl[12] = '{pimp, 6, 0, 6};
    tbl[13] = '{pimp, 7, 0, 3};
    tbl[14] = '{pimn, 1, 0, -16};
    tbl[15] = '{p000, 1, 0, -1984};
    tbl[16] = '{p000, 0, 3, -1472};
    tbl[17] = '{pimp, 3, 5, 0};

    // reset state
    tick(3);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_prod_valid", int'(prod_valid), 0);
    check("rst_sum_valid", int'(sum_valid), 0);
    check("rst_n0", int'(n0), 0);
    check("rst_n7", int'(n7), 0);
    check("rst_prod_k", int'(prod_k), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // zero row: sum_valid must pulse for exactly 8 cycles
    send_row(p128, w);
    drain();
    check("zero_row_sum_run", last_sum_run, 8);

    // table vectors
    for (int t = 0; t < 18; t++) begin
      send_row(tbl[t].pix, w);
      drain();
      check($sformatf("tbl%0d_n%0d_k%0d", t, tbl[t].i, tbl[t].k),
            cap[tbl[t].k][tbl[t].i], tbl[t].exp_n);
    end

    // back-to-back rows with in_valid held
    send_row({$urandom, $urandom}, w);
    send_row({$urandom, $urandom}, w);
    check("b2b_ready_low_cycles", w, 7);
    drain();
    check("b2b_prod_run", last_run, 16);

    // in_valid pulse at k == 3 is ignored
    send_row(p255, w);
    tick(3);
    check("k3_in_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    pix_in   = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
    drain();
    check("k3_prod_run", last_run, 8);

    // reset at k == 4 aborts the row
    send_row(pimp, w);
    tick(4);
    rst = 1'b1;
    exp_q.delete();
    sum_q.delete();
    tick();
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_prod_valid", int'(prod_valid), 0);
    check("abort_sum_valid", int'(sum_valid), 0);
    check("abort_prod_k", int'(prod_k), 0);
    check("abort_n0", int'(n0), 0);
    check("abort_n_or", int'(|{n1, n2, n3, n4, n5, n6, n7}), 0);
    check("abort_state", int'(fsm_state), int'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("abort_ready_after", int'(in_ready), 1);
    tick(20);

    // random rows, mixing back-to-back and idle gaps
    for (int r = 0; r < 30; r++) begin
      send_row({$urandom, $urandom}, w);
      if ($urandom_range(0, 1) == 1) tick($urandom_range(7, 12));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
